// File: rtl/led_rotation_decoder_pkg.sv
// Shared types and helpers for the rotating-LED decoder: FSM states,
// one-hot position constants and ring adjacency functions.
package led_rotation_decoder_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam logic [3:0] Led0 = 4'b0001;
  localparam logic [3:0] Led1 = 4'b0010;
  localparam logic [3:0] Led2 = 4'b0100;
  localparam logic [3:0] Led3 = 4'b1000;

  // Next position MSB-ward on the ring (1000 wraps to 0001).
  function automatic logic [3:0] next_up(input logic [3:0] led);
    return {led[2:0], led[3]};
  endfunction

  // Next position LSB-ward on the ring (0001 wraps to 1000).
  function automatic logic [3:0] next_dn(input logic [3:0] led);
    return {led[0], led[3:1]};
  endfunction

  function automatic logic is_onehot(input logic [3:0] led);
    return (led != 4'b0000) && ((led & (led - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hff) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/led_rotation_decoder_interval_timer.sv
// 8-bit saturating interval counter with synchronous clear and a flag that
// fires on the clock where the counter reaches TIMEOUT.
module interval_timer
  import led_rotation_decoder_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  output logic [7:0] count_o,
  output logic       timeout_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d   = clear_i ? 8'd0 : sat_inc(count_q);
    timeout_o = !clear_i && (count_d >= TIMEOUT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/led_rotation_decoder.sv
// Decodes a rotating one-hot LED pattern into direction, step count and step
// period, locking once CONFIRM consistent steps have been observed.
module led_rotation_decoder
  import led_rotation_decoder_pkg::*;
#(
  parameter logic [7:0]  TIMEOUT = 8'd255,
  parameter int unsigned CONFIRM = 2
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic [3:0] led_in,
  output logic       dir,
  output logic [7:0] step_count,
  output logic [7:0] period,
  output logic       locked,
  output logic       err
);

  state_e     state_q;
  logic [3:0] prev_led_q;
  logic       armed_q;
  logic       dir_q;
  logic       locked_q;
  logic       err_q;
  logic [7:0] step_count_q;
  logic [7:0] period_q;
  logic [7:0] confirm_q;

  logic       change;
  logic       valid;
  logic       step_up;
  logic       step_dn;
  logic       step;
  logic       illegal;
  logic       same_dir;
  logic       enter_track;
  logic       timer_clear;
  logic       timeout;
  logic [7:0] interval;
  logic [7:0] confirm_nxt;

  // armed_q is low for the first clock after reset so the initial load of
  // prev_led_q is never mistaken for a pattern change.
  always_comb begin
    change      = armed_q && (led_in != prev_led_q);
    valid       = is_onehot(led_in);
    step_up     = change && valid && (led_in == next_up(prev_led_q));
    step_dn     = change && valid && (led_in == next_dn(prev_led_q));
    step        = step_up || step_dn;
    illegal     = (state_q == StIdle) ? (change && !valid) : (change && !step);
    enter_track = (state_q == StIdle) && armed_q && valid;
    same_dir    = (step_up == dir_q);
    confirm_nxt = ((confirm_q == 8'd0) || same_dir) ? confirm_q + 8'd1 : 8'd1;
    timer_clear = change || enter_track;
  end

  interval_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_interval_timer (
    .clk_i    (in_clk),
    .rst_i    (rst),
    .clear_i  (timer_clear),
    .count_o  (interval),
    .timeout_o(timeout)
  );

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prev_led_q   <= 4'b0000;
      armed_q      <= 1'b0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      step_count_q <= 8'd0;
      period_q     <= 8'd0;
      confirm_q    <= 8'd0;
    end else begin
      prev_led_q <= led_in;
      armed_q    <= 1'b1;
      err_q      <= 1'b0;
      // An illegal change outranks everything, including a coincident timeout.
      if (illegal) begin
        state_q   <= StIdle;
        err_q     <= 1'b1;
        locked_q  <= 1'b0;
        confirm_q <= 8'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            confirm_q <= 8'd0;
            if (enter_track) begin
              state_q <= StTrack;
            end
          end
          StTrack: begin
            if (step) begin
              dir_q     <= step_up;
              period_q  <= sat_inc(interval);
              confirm_q <= confirm_nxt;
              // The confirming step is the first step counted while locked.
              if (32'(confirm_nxt) >= CONFIRM) begin
                state_q      <= StLocked;
                locked_q     <= 1'b1;
                step_count_q <= step_count_q + 8'd1;
              end
            end
          end
          StLocked: begin
            if (step) begin
              period_q <= sat_inc(interval);
              if (same_dir) begin
                step_count_q <= step_count_q + 8'd1;
              end else begin
                state_q   <= StTrack;
                dir_q     <= step_up;
                confirm_q <= 8'd1;
                locked_q  <= 1'b0;
              end
            end else if (timeout) begin
              state_q   <= StIdle;
              locked_q  <= 1'b0;
              confirm_q <= 8'd0;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign dir        = dir_q;
  assign step_count = step_count_q;
  assign period     = period_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_led_rotation_decoder.sv
// Randomised and directed bench for led_rotation_decoder; a position/timestamp
// reference model feeds a scoreboard checked once per clock by a monitor.
module tb_led_rotation_decoder;

  localparam logic [7:0]  TIMEOUT = 8'd255;
  localparam int unsigned CONFIRM = 2;
  localparam int MIdle   = 0;
  localparam int MTrack  = 1;
  localparam int MLocked = 2;

  typedef struct packed {
    logic       dir;
    logic [7:0] steps;
    logic [7:0] period;
    logic       locked;
    logic       err;
  } obs_t;

  logic       in_clk = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] led_in = 4'b0000;
  logic       dir;
  logic [7:0] step_count;
  logic [7:0] period;
  logic       locked;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  obs_t sb[$];

  led_rotation_decoder #(
    .TIMEOUT(TIMEOUT),
    .CONFIRM(CONFIRM)
  ) dut (
    .in_clk    (in_clk),
    .rst       (rst),
    .led_in    (led_in),
    .dir       (dir),
    .step_count(step_count),
    .period    (period),
    .locked    (locked),
    .err       (err)
  );

  always #5 in_clk = ~in_clk;

  // Reference model: ring positions 0..3 and the cycle index of the last change.
  int         cyc = 0;
  int         m_mode, m_conf, m_steps, m_period, m_last;
  bit         m_dir, m_locked, m_err, m_armed;
  logic [3:0] m_prev;

  function automatic int pos_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return one << (p % 4);
  endfunction

  task automatic model_edge(input logic [3:0] led, input logic r);
    int d;
    bit chg, valid, up;
    cyc++;
    if (r) begin
      m_mode = MIdle; m_dir = 0; m_steps = 0; m_period = 0; m_locked = 0;
      m_err = 0; m_conf = 0; m_prev = 4'b0000; m_armed = 0; m_last = cyc;
      return;
    end
    m_err = 0;
    chg   = m_armed && (led != m_prev);
    valid = ($countones(led) == 1);
    d     = (valid && m_mode != MIdle) ? (pos_of(led) - pos_of(m_prev) + 4) % 4 : 0;
    up    = (d == 1);
    if (chg && (!valid || (m_mode != MIdle && d == 2))) begin
      m_mode = MIdle; m_err = 1; m_locked = 0; m_conf = 0;
    end else if (m_mode == MIdle) begin
      if (m_armed && valid) begin
        m_mode = MTrack; m_conf = 0; m_last = cyc;
      end
    end else if (chg) begin
      m_period = (cyc - m_last > 255) ? 255 : cyc - m_last;
      if (m_mode == MTrack) begin
        m_conf = (m_conf == 0 || up == m_dir) ? m_conf + 1 : 1;
        m_dir  = up;
        if (m_conf >= int'(CONFIRM)) begin
          m_mode = MLocked; m_locked = 1; m_steps++;
        end
      end else if (up == m_dir) begin
        m_steps++;
      end else begin
        m_mode = MTrack; m_conf = 1; m_dir = up; m_locked = 0;
      end
    end else if (m_mode == MLocked && cyc - m_last >= int'(TIMEOUT)) begin
      m_mode = MIdle; m_locked = 0; m_conf = 0;
    end
    if (chg) m_last = cyc;
    m_prev  = led;
    m_armed = 1;
  endtask

  // Drive one clock of stimulus; the expected outputs are queued after the edge.
  task automatic cyc1(input logic [3:0] led, input logic r);
    obs_t e;
    @(negedge in_clk);
    led_in = led;
    rst    = r;
    model_edge(led, r);
    e.dir    = m_dir;
    e.steps  = 8'(m_steps % 256);
    e.period = 8'(m_period);
    e.locked = m_locked;
    e.err    = m_err;
    @(posedge in_clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic run(input logic [3:0] led, input int n);
    repeat (n) cyc1(led, 1'b0);
  endtask

  task automatic do_reset(input logic [3:0] led, input int n);
    repeat (n) cyc1(led, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared on the falling edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge in_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{dir: dir, steps: step_count, period: period, locked: locked, err: err};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got dir=%0b steps=%0d period=%0d locked=%0b err=%0b, expected dir=%0b steps=%0d period=%0d locked=%0b err=%0b",
                   $time, a.dir, a.steps, a.period, a.locked, a.err,
                   e.dir, e.steps, e.period, e.locked, e.err);
        end
      end
    end
  end

  initial begin
    int         p;
    int         r;
    logic [3:0] cur, nxt;

    // MSB-ward rotation every 4 clocks.
    do_reset(4'b0001, 2);
    chk("reset_step_count", 32'(step_count), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_dir_period", {dir, period}, 0);
    run(4'b0001, 4);
    run(4'b0010, 4);
    run(4'b0100, 1);
    chk("up_locked_after_2nd", 32'(locked), 1);
    run(4'b0100, 3);
    run(4'b1000, 4);
    run(4'b0001, 4);
    chk("up_dir", 32'(dir), 1);
    chk("up_period", 32'(period), 4);
    chk("up_step_count", 32'(step_count), 3);

    // LSB-ward rotation including the 0001->1000 wrap.
    do_reset(4'b1000, 2);
    run(4'b1000, 4);
    run(4'b0100, 4);
    run(4'b0010, 4);
    run(4'b0001, 4);
    run(4'b1000, 4);
    chk("dn_dir", 32'(dir), 0);
    chk("dn_locked", 32'(locked), 1);
    chk("dn_step_count", 32'(step_count), 3);
    chk("dn_no_err", 32'(err), 0);

    // Two-position jump while locked.
    do_reset(4'b0001, 2);
    run(4'b0001, 3);
    run(4'b0010, 3);
    run(4'b0100, 3);
    cyc1(4'b0001, 1'b0);
    chk("jump_err_pulse", 32'(err), 1);
    chk("jump_unlock", 32'(locked), 0);
    cyc1(4'b0001, 1'b0);
    chk("jump_err_one_cycle", 32'(err), 0);
    chk("jump_step_held", 32'(step_count), 1);

    // Timeout: lock drops exactly TIMEOUT clocks after the last change.
    do_reset(4'b0001, 2);
    run(4'b0001, 3);
    run(4'b0010, 3);
    run(4'b0100, 3);
    run(4'b0100, 252);
    chk("timeout_not_yet", 32'(locked), 1);
    cyc1(4'b0100, 1'b0);
    chk("timeout_unlock", 32'(locked), 0);
    chk("timeout_no_err", 32'(err), 0);
    chk("timeout_period_kept", 32'(period), 3);

    // Long hold in TRACK saturates period, then 260 steps wrap step_count.
    do_reset(4'b0001, 2);
    run(4'b0001, 302);
    cyc1(4'b0010, 1'b0);
    chk("track_period_sat", 32'(period), 255);
    run(4'b0010, 1);
    p = 1;
    for (int i = 0; i < 260; i++) begin
      p = (p + 1) % 4;
      run(oh(p), 2);
    end
    chk("wrap_step_count", 32'(step_count), 4);
    chk("wrap_locked", 32'(locked), 1);
    chk("wrap_period", 32'(period), 2);

    // One-clock reset mid-rotation, then fresh re-lock.
    cyc1(oh(p), 1'b1);
    chk("midrst_outputs", {23'd0, dir, step_count, period, locked, err}, 0);
    run(oh(p), 3);
    run(oh(p + 1), 2);
    chk("relock_needs_confirm", 32'(locked), 0);
    run(oh(p + 2), 2);
    chk("relock_done", 32'(locked), 1);

    // Random walk: steps, reversals, jumps, illegal patterns, resets, long holds.
    cur = oh(p + 2);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if ($countones(cur) != 1 && r < 76) begin
        nxt = oh($urandom_range(0, 3));
      end else if (r < 40) begin
        nxt = oh(pos_of(cur) + 1);
      end else if (r < 70) begin
        nxt = oh(pos_of(cur) + 3);
      end else if (r < 76) begin
        nxt = oh(pos_of(cur) + 2);
      end else if (r < 82) begin
        do nxt = 4'($urandom_range(0, 15)); while ($countones(nxt) == 1);
      end else begin
        nxt = cur;
      end
      if (r >= 82 && r < 84) begin
        cyc1(cur, 1'b1);
      end
      cur = nxt;
      run(cur, (r >= 84 && r < 86) ? 260 : $urandom_range(1, 6));
    end

    run(cur, 2);
    @(negedge in_clk);
    @(negedge in_clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_rotation_decoder.md
LED_ROTATION_DECODER -- requirements
Module: led_rotation_decoder

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: idle clocks in LOCKED before lock is dropped.
REQ-002 Parameter CONFIRM, default 2: consecutive consistent steps required to assert locked.
REQ-003 in_clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 led_in  input  4  observed rotating LED pattern; one-hot when valid.
REQ-006 dir  output  1  rotation direction: 1 = MSB-ward (0001->0010->0100->1000->0001), 0 = LSB-ward.
REQ-007 step_count  output  8  steps counted in LOCKED, modulo 256.
REQ-008 period  output  8  clocks between the last two pattern changes, saturating at 255.
REQ-009 locked  output  1  high while the rotation is confirmed.
REQ-010 err  output  1  one-cycle pulse on an illegal pattern or transition.

Function
REQ-011 led_in SHALL be registered once (prev_led); a change SHALL be detected when led_in != prev_led.
REQ-012 States SHALL be IDLE, TRACK, LOCKED.
REQ-013 IDLE: on a valid one-hot led_in, latch it and go to TRACK; clear the interval counter.
REQ-014 TRACK: on a change to the adjacent MSB-ward or LSB-ward position (with 1000<->0001 wrap), set dir and increment the confirm count; a step opposite to the current dir SHALL restart the confirm count at 1 with the new dir.
REQ-015 TRACK->LOCKED SHALL occur on the cycle the confirm count reaches CONFIRM; locked SHALL rise one clock after the confirming change is sampled.
REQ-016 LOCKED: each adjacent step in dir SHALL increment step_count (255 wraps to 0) and load period with the interval counter value.
REQ-017 LOCKED: a step opposite to dir SHALL return to TRACK with confirm count 1, flip dir, deassert locked and hold step_count.
REQ-018 Any non-one-hot led_in (0000 or multiple bits), or a jump of two positions, SHALL pulse err for one cycle and force IDLE from any state; step_count SHALL be held.
REQ-019 The interval counter SHALL increment every clock without a change, saturate at 255, and clear on each change.
REQ-020 LOCKED with the interval counter reaching TIMEOUT SHALL drop to IDLE, deassert locked, and leave err low.
REQ-021 When an illegal pattern and a timeout coincide, err SHALL win (err pulses, IDLE entered).
REQ-022 The change in the first cycle after reset SHALL be ignored: prev_led loads without a step.

Reset
REQ-023 On rst=1 at a clock edge: state=IDLE, dir=0, step_count=0, period=0, locked=0, err=0, confirm count=0, interval counter=0, prev_led=0000.
REQ-024 Reset asserted mid-rotation SHALL take effect on the next edge regardless of state; there SHALL be no asynchronous path.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE/TRACK/LOCKED), the 4-bit one-hot constants, and adjacency functions (next_up, next_dn).
REQ-026 One sub-module, interval_timer (8-bit saturating counter with clear and TIMEOUT compare), SHALL be instantiated; all other logic stays in the top module.
REQ-027 The RTL SHALL be 120-400 lines with no latches and no combinational loops.

Verification
REQ-028 Reset, then led_in 0001,0010,0100,1000,0001 stepping every 4 clocks -> locked=1 after the 2nd step, dir=1, period=4, step_count=3 after the last step.
REQ-029 The same sequence stepping LSB-ward (1000,0100,0010,0001,1000) -> dir=0, locked=1, 1000->0001 wrap not required; 0001->1000 counted as legal.
REQ-030 Locked MSB-ward, then led_in 0100->0001 (jump) -> err high exactly one cycle, locked=0, state IDLE, step_count held.
REQ-031 Locked, led_in held for 255 clocks with TIMEOUT=255 -> locked falls, err stays 0, period remains the last value.
REQ-032 Locked with 256+ steps -> step_count wraps 255->0 with no err; interval held >255 clocks in TRACK -> period saturates at 255 on the next step.
REQ-033 rst pulsed for 1 clock mid-rotation -> all outputs equal the reset values on the following cycle; re-lock requires CONFIRM fresh steps.
